// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: CPU data-bus bundle between the processor (master) and
// the memory-mapped UART receiver (slave).
//   address  byte address of the access (dmem_addr)
//   re       read strobe, one cycle per load
//   we       write strobe (dmem_we)
//   data_in  write data (dmem_out)
//   rd_data  read data returned by the peripheral, combinational from address
interface uart_rx_mmio_if;
  logic [31:0] address;
  logic        re;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] rd_data;

  modport master (output address, re, we, data_in, input rd_data);
  modport slave  (input address, re, we, data_in, output rd_data);
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a small byte FIFO.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   rx   asynchronous serial input, idle high
//   bus  CPU data bus (slave side): DATA at BASE, STATUS at BASE+4
//   irq  registered level interrupt: FIFO non-empty or any sticky error flag
// STATUS = {24'h0, 2'b0, count[2:0], ferr, ovr, valid}.
module uart_rx_mmio #(
  parameter logic [31:0] BASE       = 32'h0000_0F10,
  parameter int          DIV        = 868,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_mmio_if.slave  bus,
  output logic           irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(DIV);
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic                  rx_meta_reg, rx_s_reg;
  logic [1:0]            state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [2:0]            bit_reg;
  logic [7:0]            shift_reg;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  ovr_reg, ferr_reg, irq_reg;

  logic sel_data, sel_status, stop_sample, push_req, frame_err;
  logic full, pop, push, overrun, clr_ovr, clr_ferr, valid;
  logic [2:0] count3;
  logic unused_data_bits;

  assign sel_data    = (bus.address == BASE);
  assign sel_status  = (bus.address == BASE + 32'd4);
  assign valid       = (count_reg != '0);
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign stop_sample = (state_reg == ST_STOP) && (cnt_reg == DIV_LAST);
  assign push_req    = stop_sample && rx_s_reg;
  assign frame_err   = stop_sample && !rx_s_reg;
  assign pop         = bus.re && sel_data && valid;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push        = push_req && (!full || pop);
  assign overrun     = push_req && full && !pop;
  assign clr_ovr     = bus.we && sel_status && bus.data_in[1];
  assign clr_ferr    = bus.we && sel_status && bus.data_in[2];
  assign count3      = 3'(count_reg);
  assign unused_data_bits = ^{bus.data_in[31:3], bus.data_in[0]};
  assign irq         = irq_reg;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // Receive FSM. START waits half a bit so later samples land mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (!rx_s_reg) state_reg <= ST_START;
        end
        ST_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= rx_s_reg ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s_reg, shift_reg[7:1]};
            if (bit_reg == 3'd7) state_reg <= ST_STOP;
            else                 bit_reg   <= bit_reg + 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr_reg] <= shift_reg;
  end

  // Pointers, occupancy, sticky flags (set wins over clear) and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovr_reg    <= 1'b0;
      ferr_reg   <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      ovr_reg  <= overrun   | (ovr_reg  & ~clr_ovr);
      ferr_reg <= frame_err | (ferr_reg & ~clr_ferr);
      // Built from registered state, so irq trails FIFO/flags by one cycle.
      irq_reg  <= valid | ovr_reg | ferr_reg;
    end
  end

  // Read mux; DATA shows the head (pre-pop) byte, 0 when empty.
  always_comb begin
    bus.rd_data = 32'h0;
    if (sel_data && valid)
      bus.rd_data = {24'h0, mem[rd_ptr_reg]};
    else if (sel_status)
      bus.rd_data = {24'h0, 2'b00, count3, ferr_reg, ovr_reg, valid};
  end

endmodule
